// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, fetches over imem req/ack, feeds IF/ID; 1 instr/cycle when ack lands in the req cycle.
// stall_i freezes presented outputs (req drops in HOLD); IF_ALIGN_CHECK_EN adds misalign_o and word-aligns branch targets.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] PC_Inc_o,
    output logic [31:0] Instr_o,
    output logic        valid_o,
    output logic        flush_o,
    output logic        fetch_busy_o
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic [31:0] r_pc_inc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_flush;

    logic [31:0] w_target;
    logic [31:0] w_pc_next;
    logic        w_req;

`ifdef IF_ALIGN_CHECK_EN
    logic        r_misalign;
    assign w_target   = {branch_target_i[31:2], 2'b00};
    assign misalign_o = r_misalign;
`else
    assign w_target   = branch_target_i;
`endif

    assign w_pc_next = r_pc + 32'(PC_STEP);

    // Request is gated by rst so it is low for the whole reset cycle and rises with the first active cycle.
    assign w_req = rst && (r_state != S_HOLD);

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_addr;
    assign fetch_busy_o = w_req && !imem_ack_i;
    assign PC_Inc_o     = r_pc_inc;
    assign Instr_o      = r_instr;
    assign valid_o      = r_valid;
    assign flush_o      = r_flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_addr   <= RESET_PC;
            r_pc_inc <= 32'h0;
            r_instr  <= 32'h0;
            r_valid  <= 1'b0;
            r_flush  <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            r_flush <= branch_i;
`ifdef IF_ALIGN_CHECK_EN
            r_misalign <= branch_i && (branch_target_i[1:0] != 2'b00);
`endif
            case (r_state)
                S_FETCH: begin
                    if (branch_i) begin
                        // A fetch still unanswered must be drained; its address stays on the bus.
                        r_pc    <= w_target;
                        r_valid <= 1'b0;
                        if (imem_ack_i) begin
                            r_addr  <= w_target;
                            r_state <= S_FETCH;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (imem_ack_i) begin
                        r_instr  <= imem_data_i;
                        r_pc_inc <= w_pc_next;
                        r_valid  <= 1'b1;
                        r_pc     <= w_pc_next;
                        r_addr   <= w_pc_next;
                        r_state  <= stall_i ? S_HOLD : S_FETCH;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (branch_i) begin
                        r_pc    <= w_target;
                        r_addr  <= w_target;
                        r_valid <= 1'b0;
                        r_state <= S_FETCH;
                    end else if (!stall_i) begin
                        // IF/ID captures the held word this cycle.
                        r_valid <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (branch_i) begin
                        r_pc <= w_target;
                    end
                    if (imem_ack_i) begin
                        r_addr  <= branch_i ? w_target : r_pc;
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: transaction-level PC model feeds a scoreboard, a negedge monitor checks outputs.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] PC_Inc_o;
    logic [31:0] Instr_o;
    logic        valid_o;
    logic        flush_o;
    logic        fetch_busy_o;
`ifdef IF_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    if_fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_i       (branch_i),
        .branch_target_i(branch_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_data_i    (imem_data_i),
        .PC_Inc_o       (PC_Inc_o),
        .Instr_o        (Instr_o),
        .valid_o        (valid_o),
        .flush_o        (flush_o),
        .fetch_busy_o   (fetch_busy_o)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .misalign_o     (misalign_o)
`endif
    );

    typedef struct {
        logic [31:0] pc_inc;
        logic [31:0] instr;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] exp_next;
    bit          branched;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef IF_ALIGN_CHECK_EN
        return t & 32'hFFFF_FFFC;
`else
        return t;
`endif
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0200;
            1:       return 32'hFFFF_FFF8;
            2:       return $urandom & 32'h0000_FFFF;
            3:       return 32'h0000_0203;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; the memory model answers only live requests, and stall may only
    // rise while nothing un-consumed is presented so that every fetched word reaches IF/ID.
    task automatic drive(input bit r, input bit a, input bit s, input bit b, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst = r;
        #1;
        if (!r) begin
            stall_i    = 1'b0;
            branch_i   = 1'b0;
            imem_ack_i = 1'b0;
            sb.delete();
            exp_next = RST_PC;
            branched = 1'b0;
        end else begin
            stall_i         = s && (stall_i || !valid_o);
            branch_i        = b;
            branch_target_i = t;
            imem_ack_i      = a && imem_req_o;
            imem_data_i     = mem_word(imem_addr_o);
            if (b && imem_req_o) branched = 1'b1;
            if (imem_ack_i) begin
                if (!branched) begin
                    exp_t e;
                    chk("fetch_addr", imem_addr_o, exp_next);
                    e.pc_inc = exp_next + 32'd4;
                    e.instr  = mem_word(exp_next);
                    e.cyc    = cyc;
                    sb.push_back(e);
                    exp_next = exp_next + 32'd4;
                end
                branched = 1'b0;
            end
            if (b) exp_next = eff_target(t);
        end
    endtask

    // Monitor: compares presented outputs and handshake rules every cycle.
    logic        p_rst = 1'b0, p_br = 1'b0, p_req = 1'b0, p_ack = 1'b0;
    logic [31:0] p_tgt = 32'h0, p_addr = 32'h0;

    always @(negedge clk) begin
        bit has_old;
        chk("fetch_busy", {31'h0, fetch_busy_o}, {31'h0, imem_req_o && !imem_ack_i});
        chk("flush", {31'h0, flush_o}, {31'h0, p_br && p_rst});
`ifdef IF_ALIGN_CHECK_EN
        chk("misalign", {31'h0, misalign_o}, {31'h0, p_br && p_rst && (p_tgt[1:0] != 2'b00)});
`endif
        if (!rst) begin
            chk("req_in_reset", {31'h0, imem_req_o}, 32'h0);
        end else begin
            if (!p_rst) begin
                chk("rst_addr", imem_addr_o, RST_PC);
                chk("rst_pc_inc", PC_Inc_o, 32'h0);
                chk("rst_instr", Instr_o, 32'h0);
                chk("rst_req", {31'h0, imem_req_o}, 32'h1);
            end
            if (p_rst && p_req && !p_ack) begin
                chk("req_held", {31'h0, imem_req_o}, 32'h1);
                chk("addr_stable", imem_addr_o, p_addr);
            end
            has_old = (sb.size() > 0) && (sb[0].cyc < cyc);
            chk("valid", {31'h0, valid_o}, {31'h0, has_old});
            if (valid_o && has_old) begin
                chk("pc_inc", PC_Inc_o, sb[0].pc_inc);
                chk("instr", Instr_o, sb[0].instr);
                if (stall_i) chk("req_in_hold", {31'h0, imem_req_o}, 32'h0);
                else         void'(sb.pop_front());
            end
            if (branch_i) sb.delete();
        end
        p_rst  = rst;
        p_br   = branch_i;
        p_tgt  = branch_target_i;
        p_req  = imem_req_o;
        p_ack  = imem_ack_i;
        p_addr = imem_addr_o;
    end

    initial begin
        rst             = 1'b0;
        stall_i         = 1'b0;
        branch_i        = 1'b0;
        branch_target_i = 32'h0;
        imem_ack_i      = 1'b0;
        imem_data_i     = 32'h0;
        exp_next        = RST_PC;
        branched        = 1'b0;

        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        repeat (12) drive(1, 1, 0, 0, 0);              // back-to-back from RESET_PC
        repeat (3) drive(1, 0, 0, 0, 0);               // delayed ack
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0);                          // ack under stall, then hold
        repeat (3) drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 32'h200);                    // branch with fetch pending
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        repeat (3) drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 32'h300);                    // branch + ack + stall
        drive(1, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 32'hFFFF_FFFC);              // wrap-around
        repeat (3) drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 32'h203);                    // misaligned target
        repeat (2) drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);                          // reset mid-fetch
        drive(0, 1, 0, 0, 0);
        repeat (3) drive(1, 1, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            bit r, a, s, b;
            r = ($urandom_range(0, 399) != 0);
            a = ($urandom_range(0, 3) != 0);
            s = stall_i ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
            b = ($urandom_range(0, 11) == 0);
            drive(r, a, s, b, pick_target());
        end

        repeat (3) drive(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
